// File: rtl/axis_tlast_enforce_if.sv
// AXI4-Stream bundle for the TLAST framing guard.
// Signals: tdata, tkeep, tvalid, tready, tlast.
// The master modport drives payload and valid. The slave modport drives ready.
interface axis_tlast_enforce_if #(
  parameter int unsigned TDATA_W = 32
) ();
  logic [TDATA_W-1:0]   tdata;
  logic [TDATA_W/8-1:0] tkeep;
  logic                 tvalid;
  logic                 tready;
  logic                 tlast;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_tlast_enforce.sv
// axis_tlast_enforce: framing guard placed between the HLS result stream and DMA S2MM.
// Every downstream packet is exactly FRAME_WORDS beats long, and TLAST is on its final beat.
// An upstream frame that ends early is zero-padded up to FRAME_WORDS beats.
// An upstream frame that runs long is cut at FRAME_WORDS beats, and its surplus beats are dropped.
// In PASS there is no data latency: the output follows the input directly.
//
// Ports:
//   aclk, aresetn     clock, synchronous active-low reset
//   s_axis (slave)    upstream stream from HLS
//   m_axis (master)   downstream stream to DMA
//   clr_status        pulse that clears the sticky flags
//   err_early         sticky flag: an upstream frame was short
//   err_late          sticky flag: an upstream frame was long
//   frame_done        one-cycle pulse after each downstream TLAST transfer
//   frame_cnt         count of downstream TLAST transfers (statistics option only)
//   early_cnt         saturating count of short frames (statistics option only)
//   late_cnt          saturating count of long frames (statistics option only)
//
// Optional feature macro: AXIS_TLAST_STATS_EN.
// When it is defined, the three statistics counters are built.
// When it is undefined, the counter outputs are tied to zero.
module axis_tlast_enforce #(
  parameter int unsigned TDATA_W     = 32,
  parameter int unsigned FRAME_WORDS = 512
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axis_tlast_enforce_if.slave   s_axis,
  axis_tlast_enforce_if.master  m_axis,
  input  logic                  clr_status,
  output logic                  err_early,
  output logic                  err_late,
  output logic                  frame_done,
  output logic [31:0]           frame_cnt,
  output logic [15:0]           early_cnt,
  output logic [15:0]           late_cnt
);

  localparam int unsigned KEEP_W = TDATA_W / 8;
  localparam int unsigned CNT_W  = (FRAME_WORDS > 2) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {ST_PASS, ST_PAD, ST_DROP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                err_early_q, err_late_q, frame_done_q;

  logic                last_beat_c;
  logic                set_early_c, set_late_c;
  logic                m_xfer_c;
  logic                s_tready_c, m_tvalid_c, m_tlast_c;
  logic [TDATA_W-1:0]  m_tdata_c;
  logic [KEEP_W-1:0]   m_tkeep_c;

  assign last_beat_c = (beat_cnt_q == LAST_IDX);

  // State register and downstream beat counter.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= ST_PASS;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state logic, datapath muxing, and repair-event detection.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    set_early_c = 1'b0;
    set_late_c  = 1'b0;
    s_tready_c  = 1'b0;
    m_tvalid_c  = 1'b0;
    m_tlast_c   = 1'b0;
    m_tdata_c   = s_axis.tdata;
    m_tkeep_c   = s_axis.tkeep;

    case (state_q)
      ST_PASS: begin
        s_tready_c = m_axis.tready;
        m_tvalid_c = s_axis.tvalid;
        m_tlast_c  = last_beat_c;
        if (s_axis.tvalid && m_axis.tready) begin
          beat_cnt_d = last_beat_c ? '0 : beat_cnt_q + CNT_W'(1);
          if (s_axis.tlast && !last_beat_c) begin
            set_early_c = 1'b1;
            state_d     = ST_PAD;
          end else if (!s_axis.tlast && last_beat_c) begin
            set_late_c = 1'b1;
            state_d    = ST_DROP;
          end
        end
      end
      ST_PAD: begin
        // Pad beats are constant, so data stays stable while the DMA stalls.
        m_tvalid_c = 1'b1;
        m_tdata_c  = '0;
        m_tkeep_c  = '1;
        m_tlast_c  = last_beat_c;
        if (m_axis.tready) begin
          beat_cnt_d = last_beat_c ? '0 : beat_cnt_q + CNT_W'(1);
          if (last_beat_c) begin
            state_d = ST_PASS;
          end
        end
      end
      ST_DROP: begin
        // Surplus beats are swallowed until the upstream frame finally ends.
        s_tready_c = 1'b1;
        if (s_axis.tvalid && s_axis.tlast) begin
          state_d = ST_PASS;
        end
      end
      default: state_d = ST_PASS;
    endcase
  end

  assign m_xfer_c = m_tvalid_c && m_axis.tready;

  // Sticky flags and the frame_done pulse. A set event wins over a same-cycle clear.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_early_q  <= 1'b0;
      err_late_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      err_early_q  <= set_early_c | (err_early_q & ~clr_status);
      err_late_q   <= set_late_c  | (err_late_q  & ~clr_status);
      frame_done_q <= m_xfer_c & m_tlast_c;
    end
  end

  // Handshake and framing outputs are forced low while reset is asserted.
  assign s_axis.tready = aresetn & s_tready_c;
  assign m_axis.tvalid = aresetn & m_tvalid_c;
  assign m_axis.tlast  = aresetn & m_tlast_c;
  assign m_axis.tdata  = m_tdata_c;
  assign m_axis.tkeep  = m_tkeep_c;

  assign err_early  = err_early_q;
  assign err_late   = err_late_q;
  assign frame_done = frame_done_q;

`ifdef AXIS_TLAST_STATS_EN
  logic [31:0] frame_cnt_q;
  logic [15:0] early_cnt_q, late_cnt_q;

  // Statistics counters. They ignore clr_status. The two error counters saturate.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      frame_cnt_q <= '0;
      early_cnt_q <= '0;
      late_cnt_q  <= '0;
    end else begin
      if (m_xfer_c && m_tlast_c) begin
        frame_cnt_q <= frame_cnt_q + 32'd1;
      end
      if (set_early_c && (early_cnt_q != 16'hFFFF)) begin
        early_cnt_q <= early_cnt_q + 16'd1;
      end
      if (set_late_c && (late_cnt_q != 16'hFFFF)) begin
        late_cnt_q <= late_cnt_q + 16'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign early_cnt = early_cnt_q;
  assign late_cnt  = late_cnt_q;
`else
  assign frame_cnt = '0;
  assign early_cnt = '0;
  assign late_cnt  = '0;
`endif

endmodule

// File: tb/tb_axis_tlast_enforce.sv
// Testbench for axis_tlast_enforce, built with FRAME_WORDS=4.
// The reference model works at frame level.
// For each upstream frame of N beats it predicts the downstream beats:
//   - the first min(N,4) beats pass through unchanged;
//   - zero pads fill the frame up to 4 beats;
//   - TLAST is set on the 4th beat only.
// The model also predicts the error flags and the statistics counters.
module tb_axis_tlast_enforce;
  localparam int unsigned TDATA_W = 32;
  localparam int unsigned FW      = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        pad;
  } beat_t;

  logic        aclk;
  logic        aresetn;
  logic        clr_status;
  logic        err_early, err_late, frame_done;
  logic [31:0] frame_cnt;
  logic [15:0] early_cnt, late_cnt;

  axis_tlast_enforce_if #(.TDATA_W(TDATA_W)) s_if ();
  axis_tlast_enforce_if #(.TDATA_W(TDATA_W)) m_if ();

  axis_tlast_enforce #(.TDATA_W(TDATA_W), .FRAME_WORDS(FW)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .clr_status (clr_status),
    .err_early  (err_early),
    .err_late   (err_late),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .early_cnt  (early_cnt),
    .late_cnt   (late_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  beat_t       up_q[$];
  beat_t       exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        exp_early, exp_late, fd_exp;
  int          exp_frames, exp_early_n, exp_late_n;
  int          m_beats, m_lasts;
  int unsigned vprob, rprob;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame-level model: queue the upstream beats and the downstream beats they should produce.
  task automatic add_frame(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = $urandom;
      b.keep = 4'($urandom_range(1, 15));
      b.last = (i == n - 1);
      b.pad  = 1'b0;
      up_q.push_back(b);
      if (i < int'(FW)) begin
        b.last = (i == int'(FW) - 1);
        exp_q.push_back(b);
      end
    end
    for (int i = n; i < int'(FW); i++) begin
      b.data = '0;
      b.keep = 4'hF;
      b.last = (i == int'(FW) - 1);
      b.pad  = 1'b1;
      exp_q.push_back(b);
    end
    if (n < int'(FW)) begin
      exp_early = 1'b1;
      exp_early_n++;
    end
    if (n > int'(FW)) begin
      exp_late = 1'b1;
      exp_late_n++;
    end
    exp_frames++;
  endtask

  // One clock: sample the handshakes at negedge, then drive new inputs 1 time unit after posedge.
  task automatic cycle();
    logic  m_x, s_x;
    beat_t e;
    @(negedge aclk);
    m_x = m_if.tvalid && m_if.tready;
    s_x = s_if.tvalid && s_if.tready;
    check("frame_done", 64'(frame_done), 64'(fd_exp));
    fd_exp = 1'b0;
    if (m_x) begin
      m_beats++;
      if (m_if.tlast) m_lasts++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat_tvalid", 64'(m_if.tvalid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("m_tdata", 64'(m_if.tdata), 64'(e.data));
        check("m_tkeep", 64'(m_if.tkeep), 64'(e.keep));
        check("m_tlast", 64'(m_if.tlast), 64'(e.last));
        if (e.pad) check("pad_s_tready", 64'(s_if.tready), 64'(0));
        fd_exp = e.last;
      end
    end
    @(posedge aclk);
    #1;
    if (s_x) void'(up_q.pop_front());
    if (!(s_if.tvalid && !s_x)) begin
      s_if.tvalid = (up_q.size() > 0) && ($urandom_range(99) < vprob);
    end
    if (up_q.size() > 0) begin
      s_if.tdata = up_q[0].data;
      s_if.tkeep = up_q[0].keep;
      s_if.tlast = up_q[0].last;
    end else begin
      s_if.tdata = '0;
      s_if.tkeep = '0;
      s_if.tlast = 1'b0;
    end
    m_if.tready = ($urandom_range(99) < rprob);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((up_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_queues_empty", 64'(up_q.size() + exp_q.size()), 64'(0));
    repeat (3) cycle();
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_err_early"}, 64'(err_early), 64'(exp_early));
    check({tag, "_err_late"},  64'(err_late),  64'(exp_late));
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    @(posedge aclk);
    #1;
    clr_status = 1'b0;
    exp_early  = 1'b0;
    exp_late   = 1'b0;
    @(negedge aclk);
    check_flags("after_clr");
    @(posedge aclk);
    #1;
  endtask

  task automatic check_stats(input string tag);
    int ef, ee, el;
`ifdef AXIS_TLAST_STATS_EN
    ef = exp_frames;
    ee = exp_early_n;
    el = exp_late_n;
`else
    ef = 0;
    ee = 0;
    el = 0;
`endif
    check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(ef));
    check({tag, "_early_cnt"}, 64'(early_cnt), 64'(ee));
    check({tag, "_late_cnt"},  64'(late_cnt),  64'(el));
  endtask

  task automatic check_gated(input string tag);
    check({tag, "_s_tready"},   64'(s_if.tready), 64'(0));
    check({tag, "_m_tvalid"},   64'(m_if.tvalid), 64'(0));
    check({tag, "_m_tlast"},    64'(m_if.tlast),  64'(0));
    check({tag, "_err_early"},  64'(err_early),   64'(0));
    check({tag, "_err_late"},   64'(err_late),    64'(0));
    check({tag, "_frame_done"}, 64'(frame_done),  64'(0));
  endtask

  task automatic reset_model();
    up_q.delete();
    exp_q.delete();
    fd_exp      = 1'b0;
    exp_early   = 1'b0;
    exp_late    = 1'b0;
    exp_frames  = 0;
    exp_early_n = 0;
    exp_late_n  = 0;
  endtask

  initial begin
    int budget;
    aresetn     = 1'b0;
    clr_status  = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    m_beats     = 0;
    m_lasts     = 0;
    vprob       = 100;
    rprob       = 100;
    reset_model();

    // Reset state.
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check_gated("reset");
    check_stats("reset");
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // A well-formed 4-beat frame.
    add_frame(4);
    drain(100);
    check_flags("good");

    // A short frame is zero-padded.
    add_frame(2);
    drain(100);
    check_flags("early");
    pulse_clr();

    // A long frame is truncated; the next frame must pass normally.
    add_frame(6);
    add_frame(4);
    drain(100);
    check_flags("late");
    pulse_clr();

    // 10 good frames with downstream backpressure.
    m_beats = 0;
    m_lasts = 0;
    rprob   = 50;
    for (int i = 0; i < 10; i++) add_frame(4);
    drain(2000);
    check("bp_beats", 64'(m_beats), 64'(40));
    check("bp_lasts", 64'(m_lasts), 64'(10));
    check_flags("bp");

    // Random frame lengths with random valid and ready patterns.
    vprob = 70;
    rprob = 60;
    for (int i = 0; i < 30; i++) add_frame($urandom_range(1, 7));
    drain(5000);
    check_flags("random");
    check_stats("random");
    pulse_clr();
    check_stats("after_clr");

    // Reset in the middle of a frame.
    vprob   = 100;
    rprob   = 100;
    m_beats = 0;
    add_frame(4);
    budget = 0;
    while (m_beats < 2 && budget < 50) begin
      cycle();
      budget++;
    end
    check("midframe_beats_before_reset", 64'(m_beats), 64'(2));
    aresetn     = 1'b0;
    s_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check_gated("midreset");
    reset_model();
    check_stats("midreset");
    @(posedge aclk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    aresetn     = 1'b1;
    add_frame(4);
    add_frame(3);
    drain(200);
    check_flags("post_reset");
    check_stats("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
